dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 83 ++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory answering dbus loads/stores with byte lanes, sign/zero extension and error reporting
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dbus_addr,
   input  logic [31:0] dbus_data_w,
   input  logic        dbus_read,
   input  logic        dbus_write,
   input  logic [2:0]  dbus_mode,
   output logic [31:0] dbus_data_r,
   output logic        dbus_ready,
   output logic        dbus_err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state;
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] addr_q, data_q, a, wd, word, ext, wd_sh, merged;
   logic [2:0] mode_q, m;
   logic [3:0] cnt, be;
   logic wr_q, err_q, wr, req, err, enter_resp;
   logic [AW-1:0] idx;
   logic [7:0] b;
   logic [15:0] h;
   always_comb begin
      a = state == IDLE ? dbus_addr : addr_q;
      wd = state == IDLE ? dbus_data_w : data_q;
      m = state == IDLE ? dbus_mode : mode_q;
      wr = state == IDLE ? dbus_write : wr_q;
      req = dbus_read | dbus_write;
      idx = a[AW+1:2];
      word = mem[idx];
      b = word[8*a[1:0] +: 8];
      h = a[1] ? word[31:16] : word[15:0];
      ext = m[1] ? word : m[0] ? {{16{h[15] & ~m[2]}}, h} : {{24{b[7] & ~m[2]}}, b};
      err = state == IDLE ? (m == 3'b011 || m[2:1] == 2'b11 || (m[1:0] == 2'b01 && a[0]) ||
                             (m[1:0] == 2'b10 && a[1:0] != 2'b00) || (a[31:2] >> AW) != 30'd0 ||
                             (wr && m[2]) || (dbus_read && dbus_write)) : err_q;
      be = m[1] ? 4'hf : m[0] ? 4'h3 << a[1:0] : 4'h1 << a[1:0];
      wd_sh = wd << {a[1:0], 3'b000};
      merged = word;
      for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? wd_sh[8*i +: 8] : word[8*i +: 8];
      enter_resp = state == IDLE ? req && LATENCY == 1 : state == WAIT && cnt == 4'd0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         addr_q <= '0;
         data_q <= '0;
         mode_q <= '0;
         wr_q <= 1'b0;
         err_q <= 1'b0;
         dbus_ready <= 1'b0;
         dbus_err <= 1'b0;
         dbus_data_r <= '0;
      end else begin
         dbus_ready <= state == RESP;
         dbus_err <= state == RESP && err_q;
         if (enter_resp && (err || !wr)) dbus_data_r <= err ? '0 : ext;
         if (state == IDLE && req) begin
            addr_q <= dbus_addr;
            data_q <= dbus_data_w;
            mode_q <= dbus_mode;
            wr_q <= dbus_write;
            err_q <= err;
            cnt <= CNT_INIT;
            state <= LATENCY == 1 ? RESP : WAIT;
         end else if (state == WAIT) begin
            if (cnt == 4'd0) state <= RESP;
            else cnt <= cnt - 4'd1;
         end else if (state == RESP) begin
            state <= IDLE;
         end
      end
   end
   always_ff @(posedge clk)
      if (state == RESP && wr_q && !err_q) mem[idx] <= merged;
endmodule
